// File: rtl/rlc_pkg.sv
// rlc_pkg: shared definitions for the RLC write-path encoder.
//   - run/level field widths and the run-counter saturation value
//   - bit positions of the six fields and the term flag in a 64-bit RLC word
//   - encoder FSM state type and the (run, level) pair type
//   - pack_word(): assembles three pairs plus the term flag into one word
package rlc_pkg;

    localparam int RUN_W   = 5;
    localparam int LEVEL_W = 16;

    localparam logic [RUN_W-1:0] RUN_MAX   = 5'd31;
    localparam logic [1:0]       LAST_LANE = 2'd3;
    localparam logic [1:0]       LAST_SLOT = 2'd2;

    // Field LSB positions inside a DRAM word.
    localparam int RUN0_LSB   = 59;
    localparam int LEVEL0_LSB = 43;
    localparam int RUN1_LSB   = 38;
    localparam int LEVEL1_LSB = 22;
    localparam int RUN2_LSB   = 17;
    localparam int LEVEL2_LSB = 1;
    localparam int TERM_BIT   = 0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SCAN,
        ST_FLUSH
    } enc_state_t;

    typedef struct packed {
        logic [RUN_W-1:0]   run;
        logic [LEVEL_W-1:0] level;
    } pair_t;

    function automatic logic [63:0] pack_word(input pair_t p0, input pair_t p1,
                                              input pair_t p2, input logic term);
        logic [63:0] w;
        w = '0;
        w[RUN0_LSB   +: RUN_W]   = p0.run;
        w[LEVEL0_LSB +: LEVEL_W] = p0.level;
        w[RUN1_LSB   +: RUN_W]   = p1.run;
        w[LEVEL1_LSB +: LEVEL_W] = p1.level;
        w[RUN2_LSB   +: RUN_W]   = p2.run;
        w[LEVEL2_LSB +: LEVEL_W] = p2.level;
        w[TERM_BIT]              = term;
        return w;
    endfunction

endpackage

// File: rtl/rlc_pack.sv
// rlc_pack: collects (run, level) pairs into three-slot RLC words and owns the
// output register toward the DRAM writer.
//   clk, rst_n   clock, synchronous active-low reset
//   wr_en, pair  write one pair into the next free slot
//   flush        write pair as the terminal pair, zero-fill, set term
//   dram_ready   downstream can take the output word this cycle
//   stall        word-completing request cannot commit this cycle
//   out_valid, out_last, out_data  output register
module rlc_pack
    import rlc_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wr_en,
    input  logic        flush,
    input  pair_t       pair,
    input  logic        dram_ready,
    output logic        stall,
    output logic        out_valid,
    output logic        out_last,
    output logic [63:0] out_data
);

    logic [1:0]  slot;
    pair_t       slot0;
    pair_t       slot1;
    logic        completes;
    logic [63:0] new_word;

    // Only a write that fills the word (third slot or terminal) needs the
    // output register; earlier slot writes never wait.
    assign completes = (wr_en && slot == LAST_SLOT) || flush;
    assign stall     = completes && out_valid && !dram_ready;

    // Slots beyond the incoming pair are zero, which is exactly what a
    // terminal word needs; a third-slot write overwrites all of them anyway.
    always_comb begin
        // NOTE: every signal driven here gets a default first so no latch is inferred.
        new_word = '0;
        case (slot)
            2'd0:    new_word = pack_word(pair,  '0,    '0,   flush);
            2'd1:    new_word = pack_word(slot0, pair,  '0,   flush);
            default: new_word = pack_word(slot0, slot1, pair, flush);
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            slot      <= '0;
            slot0     <= '0;
            slot1     <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_data  <= '0;
        end else begin
            if (out_valid && dram_ready) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end
            // NOTE: non-blocking assignments let a load below override the drain
            // above on the same edge, so the register refills with no bubble.
            if (!stall) begin
                if (completes) begin
                    out_data  <= new_word;
                    out_valid <= 1'b1;
                    out_last  <= flush;
                    slot      <= '0;
                end else if (wr_en) begin
                    if (slot == 2'd0) slot0 <= pair;
                    else              slot1 <= pair;
                    slot <= slot + 2'd1;
                end
            end
        end
    end

endmodule

// File: rtl/rlc_enc.sv
// rlc_enc: run-length encoder for 16-bit value streams on the core-to-DRAM path.
//   clk, rst_n      clock, synchronous active-low reset
//   enc_bypass_en   1 = raw pass-through (switch only while idle)
//   core_valid/core_last/core_data  input beats, four 16-bit lanes, lane 0 = [15:0]
//   enc_ready       beat accepted on core_valid & enc_ready
//   dram_ready      downstream accepts enc_data
//   enc_valid/enc_last/enc_data     RLC words, enc_last marks the term word
// One lane is scanned per cycle; pairs are packed three per word by rlc_pack.
module rlc_enc
    import rlc_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enc_bypass_en,
    input  logic        core_valid,
    input  logic        core_last,
    input  logic [63:0] core_data,
    output logic        enc_ready,
    input  logic        dram_ready,
    output logic        enc_valid,
    output logic        enc_last,
    output logic [63:0] enc_data
);

    enc_state_t         state, state_n;
    logic [1:0]         lane, lane_n;
    logic [RUN_W-1:0]   run, run_n;
    logic [63:0]        beat;
    logic               beat_last;
    logic               accept;
    logic               fsm_ready;

    logic               enc_valid_in;
    logic               pair_wr;
    logic               flush_req;
    logic               stall;
    logic [LEVEL_W-1:0] lane_val;
    pair_t              pair_in;

    logic               pk_valid;
    logic               pk_last;
    logic [63:0]        pk_data;

    // In bypass the encoder sees neither beats nor drains, so its state stays put.
    assign enc_valid_in = core_valid && !enc_bypass_en;

    assign lane_val  = beat[{lane, 4'b0000} +: LEVEL_W];
    // A saturated run emits (31, 0) even for a zero value: the 32-zero escape.
    assign pair_wr   = (state == ST_SCAN) && (lane_val != '0 || run == RUN_MAX);
    assign flush_req = (state == ST_FLUSH);
    assign pair_in   = '{run: run, level: (flush_req ? '0 : lane_val)};

    rlc_pack u_pack (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_en      (pair_wr),
        .flush      (flush_req),
        .pair       (pair_in),
        .dram_ready (dram_ready && !enc_bypass_en),
        .stall      (stall),
        .out_valid  (pk_valid),
        .out_last   (pk_last),
        .out_data   (pk_data)
    );

    always_comb begin
        state_n   = state;
        lane_n    = lane;
        run_n     = run;
        accept    = 1'b0;
        fsm_ready = 1'b0;
        case (state)
            ST_IDLE: begin
                fsm_ready = 1'b1;
                if (enc_valid_in) begin
                    accept  = 1'b1;
                    lane_n  = '0;
                    state_n = ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (!stall) begin
                    run_n  = pair_wr ? '0 : run + 5'd1;
                    lane_n = lane + 2'd1;
                    if (lane == LAST_LANE) begin
                        if (beat_last) begin
                            state_n = ST_FLUSH;
                        end else begin
                            // Back-to-back beats: take the next one as lane 3 retires.
                            fsm_ready = 1'b1;
                            if (enc_valid_in) accept  = 1'b1;
                            else              state_n = ST_IDLE;
                        end
                    end
                end
            end
            ST_FLUSH: begin
                if (!stall) begin
                    run_n   = '0;
                    state_n = ST_IDLE;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            lane      <= '0;
            run       <= '0;
            beat      <= '0;
            beat_last <= 1'b0;
        end else begin
            state <= state_n;
            lane  <= lane_n;
            run   <= run_n;
            if (accept) begin
                beat      <= core_data;
                beat_last <= core_last;
            end
        end
    end

    assign enc_ready = enc_bypass_en ? dram_ready : fsm_ready;
    assign enc_valid = enc_bypass_en ? core_valid : pk_valid;
    assign enc_last  = enc_bypass_en ? core_last  : pk_last;
    assign enc_data  = enc_bypass_en ? core_data  : pk_data;

endmodule

// File: tb/tb_rlc_enc.sv
// tb_rlc_enc: directed bench for rlc_enc. A list-based model turns each
// stream of beats into its expected RLC words; a compare process checks
// every word handed to the DRAM side and that stalled words stay stable.
module tb_rlc_enc;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enc_bypass_en;
    logic        core_valid;
    logic        core_last;
    logic [63:0] core_data;
    logic        enc_ready;
    logic        dram_ready;
    logic        enc_valid;
    logic        enc_last;
    logic [63:0] enc_data;

    int n_vec = 0;
    int n_bad = 0;

    logic [63:0] exp_data[$];
    logic        exp_last[$];
    logic [63:0] beats_q[$];

    bit          held = 1'b0;
    logic [63:0] held_data;
    logic        held_last;
    bit          toggle_done;

    rlc_enc dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .enc_bypass_en (enc_bypass_en),
        .core_valid    (core_valid),
        .core_last     (core_last),
        .core_data     (core_data),
        .enc_ready     (enc_ready),
        .dram_ready    (dram_ready),
        .enc_valid     (enc_valid),
        .enc_last      (enc_last),
        .enc_data      (enc_data)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input bit ok, input string name,
                         input logic [63:0] act, input logic [63:0] req);
        n_vec++;
        if (!ok) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // Expected words for beats_q: flatten to values, run-length code them
    // with 32-zero escapes, append the terminal pair, cut into groups of three.
    task automatic model_stream(output int nw);
        int          runs[$];
        int          levels[$];
        int          zeros;
        int          v;
        logic [63:0] w;
        zeros = 0;
        nw    = 0;
        foreach (beats_q[b]) begin
            for (int k = 0; k < 4; k++) begin
                v = int'((beats_q[b] >> (16 * k)) & 64'hFFFF);
                if (v != 0 || zeros == 31) begin
                    runs.push_back(zeros);
                    levels.push_back(v);
                    zeros = 0;
                end else begin
                    zeros++;
                end
            end
        end
        runs.push_back(zeros);
        levels.push_back(0);
        for (int i = 0; i < runs.size(); i += 3) begin
            w = '0;
            for (int j = 0; j < 3; j++) begin
                if (i + j < runs.size()) begin
                    w |= 64'(runs[i + j])   << (59 - 21 * j);
                    w |= 64'(levels[i + j]) << (43 - 21 * j);
                end
            end
            if (i + 3 >= runs.size()) w |= 64'd1;
            exp_data.push_back(w);
            exp_last.push_back(i + 3 >= runs.size());
            nw++;
        end
    endtask

    task automatic send_beat(input logic [63:0] d, input logic l);
        int cnt;
        cnt        = 0;
        core_valid = 1'b1;
        core_data  = d;
        core_last  = l;
        @(negedge clk);
        while (!enc_ready && cnt < 400) begin
            @(negedge clk);
            cnt++;
        end
        check(enc_ready === 1'b1, "accept_timeout", 64'(cnt), 64'd400);
        @(posedge clk);
        #1;
        core_valid = 1'b0;
    endtask

    task automatic send_stream();
        for (int i = 0; i < beats_q.size(); i++)
            send_beat(beats_q[i], i == beats_q.size() - 1);
    endtask

    task automatic wait_drain();
        int cnt;
        cnt = 0;
        while (exp_data.size() > 0 && cnt < 1000) begin
            @(negedge clk);
            cnt++;
        end
        check(exp_data.size() == 0, "drain_timeout", 64'(exp_data.size()), 64'd0);
        repeat (3) @(negedge clk);
        check(enc_valid == 1'b0, "idle_valid", 64'(enc_valid), 64'd0);
        @(posedge clk);
        #1;
    endtask

    // Compare process: every word taken by the DRAM side must be the next
    // expected word; a word held under backpressure must not change.
    always @(negedge clk) begin
        if (!rst_n || enc_bypass_en) begin
            held = 1'b0;
        end else if (enc_valid) begin
            if (held) begin
                check(enc_data == held_data, "hold_data", enc_data, held_data);
                check(enc_last == held_last, "hold_last", 64'(enc_last), 64'(held_last));
            end
            if (dram_ready) begin
                check(exp_data.size() > 0, "extra_word", enc_data, 64'd0);
                if (exp_data.size() > 0) begin
                    check(enc_data == exp_data[0], "word_data", enc_data, exp_data[0]);
                    check(enc_last == exp_last[0], "word_last", 64'(enc_last), 64'(exp_last[0]));
                    void'(exp_data.pop_front());
                    void'(exp_last.pop_front());
                end
                held = 1'b0;
            end else begin
                held      = 1'b1;
                held_data = enc_data;
                held_last = enc_last;
            end
        end else if (held) begin
            check(enc_valid == 1'b1, "valid_dropped", 64'(enc_valid), 64'd1);
            held = 1'b0;
        end
    end

    initial begin
        int nw;
        int base;
        rst_n         = 1'b0;
        enc_bypass_en = 1'b0;
        core_valid    = 1'b0;
        core_last     = 1'b0;
        core_data     = '0;
        dram_ready    = 1'b1;
        toggle_done   = 1'b0;

        // Reset state.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check(enc_valid == 1'b0, "rst_valid", 64'(enc_valid), 64'd0);
        check(enc_last  == 1'b0, "rst_last",  64'(enc_last),  64'd0);
        check(enc_data  == 64'd0, "rst_data", enc_data, 64'd0);
        check(enc_ready == 1'b1, "rst_ready_idle", 64'(enc_ready), 64'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Bypass: combinational pass-through, encoder must not take the beat.
        enc_bypass_en = 1'b1;
        core_valid    = 1'b1;
        core_data     = 64'h0123_4567_89AB_CDEF;
        core_last     = 1'b1;
        @(negedge clk);
        check(enc_valid == 1'b1, "byp_valid", 64'(enc_valid), 64'd1);
        check(enc_data == 64'h0123_4567_89AB_CDEF, "byp_data", enc_data, 64'h0123_4567_89AB_CDEF);
        check(enc_last == 1'b1, "byp_last", 64'(enc_last), 64'd1);
        check(enc_ready == 1'b1, "byp_ready_hi", 64'(enc_ready), 64'd1);
        @(posedge clk);
        #1;
        dram_ready = 1'b0;
        @(negedge clk);
        check(enc_ready == 1'b0, "byp_ready_lo", 64'(enc_ready), 64'd0);
        @(posedge clk);
        #1;
        core_valid = 1'b0;
        @(negedge clk);
        check(enc_valid == 1'b0, "byp_valid_lo", 64'(enc_valid), 64'd0);
        @(posedge clk);
        #1;
        enc_bypass_en = 1'b0;
        dram_ready    = 1'b1;
        core_last     = 1'b0;
        core_data     = '0;
        @(negedge clk);
        check(enc_ready == 1'b1, "post_byp_idle", 64'(enc_ready), 64'd1);
        check(enc_valid == 1'b0, "post_byp_valid", 64'(enc_valid), 64'd0);
        @(posedge clk);
        #1;

        // Dense single beat.
        beats_q = {64'h0004_0003_0002_0001};
        model_stream(nw);
        base = exp_data.size() - nw;
        check(nw == 2, "dense_nwords", 64'(nw), 64'd2);
        check(exp_data[base] == 64'h0000_0800_0080_0006, "pin_dense0", exp_data[base], 64'h0000_0800_0080_0006);
        check(exp_data[base+1] == 64'h0000_2000_0000_0001, "pin_dense1", exp_data[base+1], 64'h0000_2000_0000_0001);
        send_stream();
        wait_drain();

        // 32 zeros: escape pair then a zero terminal pair.
        beats_q = {};
        for (int i = 0; i < 8; i++) beats_q.push_back(64'd0);
        model_stream(nw);
        base = exp_data.size() - nw;
        check(nw == 1, "zero_nwords", 64'(nw), 64'd1);
        check(exp_data[base] == 64'hF800_0000_0000_0001, "pin_zero", exp_data[base], 64'hF800_0000_0000_0001);
        send_stream();
        wait_drain();

        // Sparse.
        beats_q = {64'd0, 64'h0005_0000_0000_0000};
        model_stream(nw);
        base = exp_data.size() - nw;
        check(exp_data[base] == 64'h3800_2800_0000_0001, "pin_sparse", exp_data[base], 64'h3800_2800_0000_0001);
        send_stream();
        wait_drain();

        // Backpressure over three dense beats.
        beats_q = {64'h0004_0003_0002_0001, 64'h0008_0007_0006_0005, 64'h000C_000B_000A_0009};
        model_stream(nw);
        check(nw == 5, "bp_nwords", 64'(nw), 64'd5);
        dram_ready = 1'b0;
        fork
            send_stream();
            begin
                repeat (20) @(negedge clk);
                check(enc_ready == 1'b0, "bp_ready_low", 64'(enc_ready), 64'd0);
                check(enc_valid == 1'b1, "bp_valid_held", 64'(enc_valid), 64'd1);
                check(enc_data == 64'h0000_0800_0080_0006, "bp_first_word", enc_data, 64'h0000_0800_0080_0006);
                @(posedge clk);
                #1;
                dram_ready = 1'b1;
            end
        join
        wait_drain();

        // Long zero run across beats with a randomly toggling dram_ready.
        beats_q = {64'h0000_0009_0000_0000};
        for (int i = 0; i < 10; i++) beats_q.push_back(64'd0);
        beats_q.push_back(64'hABCD_0000_0000_0001);
        model_stream(nw);
        toggle_done = 1'b0;
        fork
            begin
                send_stream();
                wait_drain();
                toggle_done = 1'b1;
            end
            begin
                while (!toggle_done) begin
                    @(posedge clk);
                    #1;
                    if (!toggle_done) dram_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        dram_ready = 1'b1;
        @(posedge clk);
        #1;

        // Reset mid-SCAN: the partial word (pair (0,7) in slot 0) is discarded.
        send_beat(64'h0000_0000_0000_0007, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check(enc_valid == 1'b0, "rst_mid_valid", 64'(enc_valid), 64'd0);
        check(enc_ready == 1'b1, "rst_mid_idle", 64'(enc_ready), 64'd1);
        @(posedge clk);
        #1;
        beats_q = {64'h0004_0003_0002_0001};
        model_stream(nw);
        base = exp_data.size() - nw;
        check(exp_data[base] == 64'h0000_0800_0080_0006, "pin_rst_dense0", exp_data[base], 64'h0000_0800_0080_0006);
        send_stream();
        wait_drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
